// File: rtl/entry_alloc_arb.sv
// entry_alloc_arb: allocation controller for a DEPTH-entry searchable table.
// Owns the entry valid vector, runs a clear sweep of the table storage after
// reset and flush, arbitrates allocation round-robin among NREQ requesters
// (each grant takes the lowest free entry), and accepts entry-free commands.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   req_i / gnt_o         per-requester level request / one-hot grant (comb)
//   gnt_index_o           entry granted this cycle (0 when no grant)
//   free_valid_i/_index_i free command
//   flush_i               invalidate everything and re-sweep
//   valid_vec_o, count_o  registered valid bits and population count
//   full_o, empty_o       count_o == DEPTH / count_o == 0
//   ready_o               high while running (not sweeping)
//   clr_we_o, clr_addr_o  table clear write port driven during the sweep
//   err_o                 sticky: a free hit an invalid or out-of-range entry
module entry_alloc_arb #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned NREQ  = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NREQ-1:0]  req_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [WIDTH-1:0] gnt_index_o,
  input  logic             free_valid_i,
  input  logic [WIDTH-1:0] free_index_i,
  input  logic             flush_i,
  output logic [DEPTH-1:0] valid_vec_o,
  output logic [WIDTH-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ready_o,
  output logic             clr_we_o,
  output logic [WIDTH-1:0] clr_addr_o,
  output logic             err_o
);

  localparam int unsigned RRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sweep_q, sweep_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [RRW-1:0]   rr_q, rr_d;
  logic             err_q, err_d;

  logic             run_act;
  logic             sweep_last;
  logic             gnt_any;
  logic [RRW-1:0]   gnt_k;
  logic [RRW-1:0]   cand;
  logic             fz_found;
  logic [WIDTH-1:0] first_zero;
  logic             free_in_range;
  logic             free_ok;
  logic             free_bad;

  assign sweep_last    = (sweep_q == WIDTH'(DEPTH - 1));
  assign run_act       = (state_q == ST_RUN) && !flush_i;
  assign free_in_range = (free_index_i < WIDTH'(DEPTH));
  assign free_ok       = run_act && free_valid_i && free_in_range &&
                         valid_q[free_index_i[AW-1:0]];
  assign free_bad      = run_act && free_valid_i && !free_ok;

  assign valid_vec_o = valid_q;
  assign count_o     = count_q;
  assign err_o       = err_q;
  assign full_o      = (count_q == WIDTH'(DEPTH));
  assign empty_o     = (count_q == '0);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_INIT;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (sweep_last) state_d = ST_RUN;
      ST_RUN:  if (flush_i)    state_d = ST_INIT;
      default: state_d = ST_INIT;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    clr_we_o   = 1'b0;
    clr_addr_o = '0;
    ready_o    = 1'b0;
    case (state_q)
      ST_INIT: begin
        clr_we_o   = 1'b1;
        clr_addr_o = sweep_q;
      end
      ST_RUN:  ready_o = 1'b1;
      default: ;
    endcase
  end

  // Round-robin pick: first set request at or after rr_q, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_k   = '0;
    cand    = '0;
    if (run_act && !full_o) begin
      for (int unsigned off = 0; off < NREQ; off++) begin
        cand = RRW'((32'(rr_q) + off) % NREQ);
        if (!gnt_any && req_i[cand]) begin
          gnt_any = 1'b1;
          gnt_k   = cand;
        end
      end
    end
  end

  // Lowest clear bit of the pre-free vector.
  always_comb begin
    fz_found   = 1'b0;
    first_zero = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!fz_found && !valid_q[AW'(i)]) begin
        fz_found   = 1'b1;
        first_zero = WIDTH'(i);
      end
    end
  end

  assign gnt_o       = gnt_any ? (NREQ'(1) << gnt_k) : '0;
  assign gnt_index_o = gnt_any ? first_zero : '0;

  // Datapath next state. Grant and free never target the same entry (grant
  // picks a clear bit, an accepted free needs a set bit), so both may commit.
  always_comb begin
    sweep_d = sweep_q;
    valid_d = valid_q;
    count_d = count_q;
    rr_d    = rr_q;
    err_d   = err_q;
    if (state_q == ST_INIT) begin
      sweep_d = sweep_last ? '0 : sweep_q + WIDTH'(1);
    end else if (flush_i) begin
      sweep_d = '0;
      valid_d = '0;
      count_d = '0;
    end else begin
      if (gnt_any) begin
        valid_d[first_zero[AW-1:0]] = 1'b1;
        rr_d = (gnt_k == RRW'(NREQ - 1)) ? '0 : gnt_k + RRW'(1);
      end
      if (free_ok)  valid_d[free_index_i[AW-1:0]] = 1'b0;
      if (free_bad) err_d = 1'b1;
      count_d = count_q + WIDTH'(gnt_any) - WIDTH'(free_ok);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sweep_q <= '0;
      valid_q <= '0;
      count_q <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      sweep_q <= sweep_d;
      valid_q <= valid_d;
      count_q <= count_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_entry_alloc_arb.sv
// Testbench for entry_alloc_arb: behavioural model feeds a scoreboard queue
// of expected per-cycle outputs; scenario tasks pop and compare them, plus
// fixed expected values from the allocation rules.
module tb_entry_alloc_arb;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  req_i = '0;
  logic [1:0]  gnt_o;
  logic [5:0]  gnt_index_o;
  logic        free_valid_i = 1'b0;
  logic [5:0]  free_index_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] valid_vec_o;
  logic [5:0]  count_o;
  logic        full_o, empty_o, ready_o, clr_we_o, err_o;
  logic [5:0]  clr_addr_o;

  always #5 clk = ~clk;

  entry_alloc_arb #(.WIDTH(6), .DEPTH(32), .NREQ(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
    .gnt_index_o(gnt_index_o), .free_valid_i(free_valid_i),
    .free_index_i(free_index_i), .flush_i(flush_i),
    .valid_vec_o(valid_vec_o), .count_o(count_o), .full_o(full_o),
    .empty_o(empty_o), .ready_o(ready_o), .clr_we_o(clr_we_o),
    .clr_addr_o(clr_addr_o), .err_o(err_o)
  );

  typedef struct packed {
    logic [1:0]  gnt;
    logic [5:0]  idx;
    logic        clr_we;
    logic [5:0]  clr_addr;
    logic        ready;
    logic [31:0] vv;
    logic [5:0]  cnt;
    logic        full;
    logic        empty;
    logic        err;
  } exp_t;

  exp_t obs, snap;
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  assign obs = {gnt_o, gnt_index_o, clr_we_o, clr_addr_o, ready_o,
                valid_vec_o, count_o, full_o, empty_o, err_o};

  // Reference model state
  bit          m_run;
  int          m_sweep, m_cnt, m_rr;
  logic [31:0] m_vv;
  bit          m_err;

  function automatic void model_reset();
    m_run = 0; m_sweep = 0; m_cnt = 0; m_rr = 0; m_vv = '0; m_err = 0;
  endfunction

  // One clock cycle: drive, push expected outputs, advance model, sample at
  // the falling edge, return 1 time unit after the rising edge.
  task automatic step(input logic [1:0] req, input logic fv,
                      input logic [5:0] fi, input logic fl);
    exp_t x;
    int   gk, fz;
    bit   acc;
    req_i = req; free_valid_i = fv; free_index_i = fi; flush_i = fl;
    x = '0;
    x.vv = m_vv; x.cnt = 6'(m_cnt); x.full = (m_cnt == 32);
    x.empty = (m_cnt == 0); x.err = m_err; x.ready = m_run;
    x.clr_we = !m_run; x.clr_addr = m_run ? 6'd0 : 6'(m_sweep);
    gk = -1; fz = 0;
    if (m_run && !fl && m_cnt < 32 && req != 2'b00) begin
      for (int o = 0; o < 2; o++)
        if (gk < 0 && req[(m_rr + o) % 2]) gk = (m_rr + o) % 2;
      for (int i = 31; i >= 0; i--)
        if (!m_vv[i]) fz = i;
      x.gnt = 2'(1 << gk);
      x.idx = 6'(fz);
    end
    sb.push_back(x);
    if (!m_run) begin
      if (m_sweep == 31) begin m_run = 1; m_sweep = 0; end
      else m_sweep++;
    end else if (fl) begin
      m_run = 0; m_sweep = 0; m_vv = '0; m_cnt = 0;
    end else begin
      acc = fv && (fi < 32) && (m_vv[fi[4:0]] == 1'b1);
      if (fv && !acc) m_err = 1;
      if (gk >= 0) begin m_vv[fz] = 1'b1; m_cnt++; m_rr = (gk + 1) % 2; end
      if (acc) begin m_vv[fi[4:0]] = 1'b0; m_cnt--; end
    end
    @(negedge clk);
    snap = obs;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_ni = 1'b0; req_i = '0; free_valid_i = 1'b0; free_index_i = '0;
    flush_i = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_ni = 1'b1;
    repeat (32) step(2'b00, 1'b0, 6'd0, 1'b0);
    sb.delete();
  endtask

  task automatic test_reset();
    exp_t e;
    rst_ni = 1'b0; req_i = 2'b11; free_valid_i = 1'b0; flush_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({gnt_o, ready_o, empty_o, full_o, valid_vec_o, count_o, err_o, clr_addr_o}
        !== {2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 6'd0, 1'b0, 6'd0}) begin
      failures++;
      $display("FAIL reset_values: gnt=%b ready=%b empty=%b full=%b vv=%h cnt=%0d err=%b addr=%0d",
               gnt_o, ready_o, empty_o, full_o, valid_vec_o, count_o, err_o, clr_addr_o);
    end
    @(posedge clk);
    #1 rst_ni = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step(2'b11, 1'b0, 6'd0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (snap !== e) begin
        failures++;
        $display("FAIL reset_sweep_sb[%0d]: got %h expected %h", i, snap, e);
      end
      checks++;
      if (snap.clr_we !== 1'b1 || snap.clr_addr !== 6'(i) || snap.gnt !== 2'b00 ||
          snap.empty !== 1'b1 || snap.ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_sweep[%0d]: we=%b addr=%0d gnt=%b empty=%b ready=%b, expected 1 %0d 00 1 0",
                 i, snap.clr_we, snap.clr_addr, snap.gnt, snap.empty, snap.ready, i);
      end
    end
    step(2'b00, 1'b0, 6'd0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (snap !== e || snap.ready !== 1'b1 || snap.clr_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got %h expected %h with ready=1", snap, e);
    end
  endtask

  task automatic test_single();
    exp_t e;
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      step(2'b01, 1'b0, 6'd0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (snap !== e || snap.gnt !== 2'b01 || snap.idx !== 6'(i)) begin
        failures++;
        $display("FAIL single[%0d]: got %h expected %h (gnt=01 idx=%0d)", i, snap, e, i);
      end
    end
    checks++;
    if (valid_vec_o !== 32'h7 || count_o !== 6'd3) begin
      failures++;
      $display("FAIL single_state: vv=%h cnt=%0d, expected 00000007 3", valid_vec_o, count_o);
    end
  endtask

  task automatic test_both();
    exp_t e;
    logic [1:0] eg [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      step(2'b11, 1'b0, 6'd0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (snap !== e || snap.gnt !== eg[i] || snap.idx !== 6'(i)) begin
        failures++;
        $display("FAIL both[%0d]: got %h expected %h (gnt=%b idx=%0d)", i, snap, e, eg[i], i);
      end
    end
  endtask

  task automatic test_fill();
    exp_t e;
    for (int i = 0; i < 28; i++) begin
      step(2'b01, 1'b0, 6'd0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (snap !== e) begin
        failures++;
        $display("FAIL fill[%0d]: got %h expected %h", i, snap, e);
      end
    end
    checks++;
    if (full_o !== 1'b1 || count_o !== 6'd32 || valid_vec_o !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL fill_full: full=%b cnt=%0d vv=%h, expected 1 32 ffffffff", full_o, count_o, valid_vec_o);
    end
    step(2'b01, 1'b0, 6'd0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (snap !== e || snap.gnt !== 2'b00) begin
      failures++;
      $display("FAIL full_blocks: got %h expected %h (gnt=00)", snap, e);
    end
    step(2'b01, 1'b1, 6'd5, 1'b0);
    e = sb.pop_front();
    checks++;
    if (snap !== e || snap.gnt !== 2'b00) begin
      failures++;
      $display("FAIL full_free_cycle: got %h expected %h (gnt=00)", snap, e);
    end
    checks++;
    if (valid_vec_o !== 32'hFFFF_FFDF || full_o !== 1'b0) begin
      failures++;
      $display("FAIL full_after_free: vv=%h full=%b, expected ffffffdf 0", valid_vec_o, full_o);
    end
    step(2'b01, 1'b0, 6'd0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (snap !== e || snap.gnt !== 2'b01 || snap.idx !== 6'd5) begin
      failures++;
      $display("FAIL reuse_5: got %h expected %h (gnt=01 idx=5)", snap, e);
    end
    checks++;
    if (full_o !== 1'b1) begin
      failures++;
      $display("FAIL refull: full=%b, expected 1", full_o);
    end
  endtask

  task automatic test_grant_free();
    exp_t e;
    reset_dut();
    repeat (2) begin
      step(2'b01, 1'b0, 6'd0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (snap !== e) begin
        failures++;
        $display("FAIL gf_setup: got %h expected %h", snap, e);
      end
    end
    step(2'b01, 1'b1, 6'd0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (snap !== e || snap.gnt !== 2'b01 || snap.idx !== 6'd2) begin
      failures++;
      $display("FAIL gf_same_cycle: got %h expected %h (gnt=01 idx=2)", snap, e);
    end
    checks++;
    if (count_o !== 6'd2 || valid_vec_o !== 32'h6) begin
      failures++;
      $display("FAIL gf_state: cnt=%0d vv=%h, expected 2 00000006", count_o, valid_vec_o);
    end
  endtask

  task automatic test_err_flush();
    exp_t e;
    step(2'b00, 1'b1, 6'd0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (snap !== e) begin
      failures++;
      $display("FAIL err_clear_free_sb: got %h expected %h", snap, e);
    end
    checks++;
    if (err_o !== 1'b1 || valid_vec_o !== 32'h6 || count_o !== 6'd2) begin
      failures++;
      $display("FAIL err_clear_free: err=%b vv=%h cnt=%0d, expected 1 00000006 2", err_o, valid_vec_o, count_o);
    end
    step(2'b00, 1'b1, 6'd40, 1'b0);
    e = sb.pop_front();
    checks++;
    if (snap !== e || err_o !== 1'b1 || valid_vec_o !== 32'h6 || count_o !== 6'd2) begin
      failures++;
      $display("FAIL err_range: got %h expected %h, err=%b vv=%h cnt=%0d", snap, e, err_o, valid_vec_o, count_o);
    end
    repeat (8) begin
      step(2'b01, 1'b0, 6'd0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (snap !== e) begin
        failures++;
        $display("FAIL flush_setup: got %h expected %h", snap, e);
      end
    end
    checks++;
    if (count_o !== 6'd10 || valid_vec_o !== 32'h3FF) begin
      failures++;
      $display("FAIL flush_pre: cnt=%0d vv=%h, expected 10 000003ff", count_o, valid_vec_o);
    end
    step(2'b11, 1'b1, 6'd1, 1'b1);
    e = sb.pop_front();
    checks++;
    if (snap !== e || snap.gnt !== 2'b00 || snap.idx !== 6'd0) begin
      failures++;
      $display("FAIL flush_cycle: got %h expected %h (gnt=00)", snap, e);
    end
    checks++;
    if (valid_vec_o !== 32'h0 || count_o !== 6'd0 || ready_o !== 1'b0 ||
        clr_we_o !== 1'b1 || err_o !== 1'b1) begin
      failures++;
      $display("FAIL flush_after: vv=%h cnt=%0d ready=%b we=%b err=%b, expected 0 0 0 1 1",
               valid_vec_o, count_o, ready_o, clr_we_o, err_o);
    end
    for (int i = 0; i < 32; i++) begin
      step(2'b00, 1'b0, 6'd0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (snap !== e || snap.clr_addr !== 6'(i)) begin
        failures++;
        $display("FAIL flush_sweep[%0d]: got %h expected %h", i, snap, e);
      end
    end
    step(2'b00, 1'b0, 6'd0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (snap !== e || snap.ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_ready: got %h expected %h (ready=1)", snap, e);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    step(2'b00, 1'b0, 6'd0, 1'b1);
    e = sb.pop_front();
    checks++;
    if (snap !== e) begin
      failures++;
      $display("FAIL mid_flush: got %h expected %h", snap, e);
    end
    for (int i = 0; i < 17; i++) begin
      step(2'b11, 1'b0, 6'd0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (snap !== e) begin
        failures++;
        $display("FAIL mid_sweep[%0d]: got %h expected %h", i, snap, e);
      end
    end
    checks++;
    if (clr_addr_o !== 6'd17 || err_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre: addr=%0d err=%b, expected 17 1", clr_addr_o, err_o);
    end
    rst_ni = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({clr_addr_o, clr_we_o, ready_o, err_o, count_o, valid_vec_o, gnt_o, empty_o}
        !== {6'd0, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 2'b00, 1'b1}) begin
      failures++;
      $display("FAIL mid_reset_async: addr=%0d we=%b ready=%b err=%b cnt=%0d vv=%h gnt=%b empty=%b",
               clr_addr_o, clr_we_o, ready_o, err_o, count_o, valid_vec_o, gnt_o, empty_o);
    end
    @(posedge clk);
    #1 rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(2'b11, 1'b0, 6'd0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (snap !== e || snap.clr_addr !== 6'(i)) begin
        failures++;
        $display("FAIL mid_restart[%0d]: got %h expected %h", i, snap, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_both();
    test_fill();
    test_grant_free();
    test_err_flush();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/entry_alloc_arb.md
Name: entry_alloc_arb

Overview:
- Allocation controller for a 32-entry searchable table.
- Owns the entry valid vector and runs a power-up/flush clear sweep of the table storage.
- Shares allocation between NREQ requesters with round-robin arbitration. Each grant goes to the lowest-indexed free entry (first-zero priority encode of the valid vector).
- Takes entry-free commands and publishes the valid vector to the parallel-search logic.

Parameters:
- WIDTH, 6, index/count width; must hold the value DEPTH.
- DEPTH, 32, number of table entries.
- NREQ, 2, number of allocation requesters.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  NREQ  per-requester allocation request, level
- gnt_o  out  NREQ  one-hot grant, combinational, same cycle as req
- gnt_index_o  out  WIDTH  entry index granted; valid when |gnt_o
- free_valid_i  in  1  free command strobe
- free_index_i  in  WIDTH  entry to free
- flush_i  in  1  single-cycle pulse: invalidate all entries and re-sweep
- valid_vec_o  out  DEPTH  registered entry valid bits
- count_o  out  WIDTH  number of valid entries, 0..DEPTH
- full_o  out  1  count_o == DEPTH
- empty_o  out  1  count_o == 0
- ready_o  out  1  high in RUN only
- clr_we_o  out  1  table clear write enable (INIT sweep)
- clr_addr_o  out  WIDTH  table clear address
- err_o  out  1  sticky error flag

Behaviour:
- Reset (async assert, rst_ni low):
  - state=INIT, sweep counter=0, valid_vec_o=0, count_o=0, rr pointer=0, err_o=0.
  - Outputs while in INIT: gnt_o=0, ready_o=0, empty_o=1, full_o=0.
- FSM states: INIT, RUN.
- INIT:
  - clr_we_o=1, clr_addr_o=sweep counter; counter increments each cycle.
  - After clr_addr_o==DEPTH-1 is issued, next state is RUN. The sweep takes exactly DEPTH cycles.
  - req_i is ignored, free commands are dropped, flush_i is ignored.
- RUN:
  - clr_we_o=0, clr_addr_o=0, ready_o=1.
  - flush_i=1 → next cycle: state=INIT, sweep counter=0, valid_vec_o=0, count_o=0. Any grant or free in the flush cycle is suppressed; gnt_o=0 in that cycle.
- Arbitration (RUN, no flush, full_o=0, any req_i):
  - The search starts at the rr pointer and takes the first set req_i in ascending order modulo NREQ. That requester k gets gnt_o[k]=1.
  - gnt_index_o = lowest i with valid_vec_o[i]==0.
  - At the clock edge: valid bit set, rr pointer = (k+1) mod NREQ.
  - The rr pointer is unchanged when there is no grant.
  - At most one grant per cycle.
- Handshake: a requester samples gnt_o in the same cycle and must drop req_i the next cycle. Holding req_i high requests another entry.
- full_o=1: gnt_o=0, the rr pointer holds, requests wait; no error.
- Free (RUN, no flush):
  - free_valid_i with free_index_i<DEPTH and bit set → bit clears at the edge.
  - free_index_i>=DEPTH, or target bit already clear → command ignored, err_o set to 1. err_o stays set until reset.
- Simultaneous grant and free:
  - Both commit; count_o unchanged.
  - The grant searches the pre-free vector, so a freed entry is reusable from the next cycle, never the same cycle.
- count_o: next = count + grant − accepted_free. It never wraps: full blocks grants and rejected frees do not decrement.
- gnt_index_o is 0 when there is no grant.
- valid_vec_o, count_o, full_o, empty_o are registered from the state after the edge.
- Reset mid-sweep or mid-run returns asynchronously to the reset values above; the sweep restarts at 0.

Test Plan:
- Reset release:
  - clr_we_o high for exactly 32 cycles, clr_addr_o 0..31.
  - ready_o rises on cycle 33; empty_o=1, gnt_o=0 throughout, even with req_i=2'b11 held.
- Single requester, req_i=2'b01 held 3 cycles:
  - gnt_index_o 0,1,2 on consecutive cycles; count_o 3; valid_vec_o=32'h7.
- Both requesting, req_i=2'b11 held 4 cycles from rr=0:
  - gnt_o 01,10,01,10; gnt_index_o 0,1,2,3.
- Fill to full with 32 grants:
  - full_o=1 and further req gets gnt_o=0.
  - Then free_index_i=5 with req_i=2'b01 in the same cycle → no grant in that cycle (full); next cycle gnt_index_o=5, full_o returns 1.
- With valid_vec=32'h3, grant and free_index_i=0 in the same cycle:
  - gnt_index_o=2, count_o stays 2, valid_vec_o=32'h6.
- Error and flush:
  - Free of a clear entry, then free_index_i=40 → err_o=1 and stays 1; valid_vec_o unchanged.
  - flush_i in RUN with 10 valid entries → next cycle valid_vec_o=0, count_o=0, 32-cycle sweep, then ready_o=1.
  - Assert rst_ni low mid-sweep at addr 17 → immediate reset values, sweep restarts from 0.
